// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Two-master arbiter in front of the single-port on-chip SRAM (32-bit words,
// 1-cycle read latency). Master 0 is the Nios II data master, master 1 the
// coprocessor DMA/result-writer. At most one SRAM access is issued per cycle.
// Read data is steered back to the issuing master via a one-stage tag.
// Accesses at or beyond DEPTH are accepted but never reach the SRAM: writes
// are dropped, reads return zero, and each one is counted as an error.
//
// Ports
//   clk, reset_n          system clock, synchronous active-low reset
//   reset_req             SRAM freeze: no grants, sram_clken low
//   mN_*                  Avalon-MM style slave port per master (N = 0, 1)
//   sram_*                single-port SRAM interface
//   err_count, err_pulse  saturating out-of-range count, 1-cycle pulse
// ---------------------------------------------------------------------------

// Per-master request decode: request present, write wins over read, range.
module sram_port_arbiter_req #(
    parameter int AW    = 12,
    parameter int DEPTH = 2560
) (
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    output logic          req,
    output logic          is_wr,
    output logic          in_rng
);
    assign req    = rd | wr;
    assign is_wr  = wr;
    assign in_rng = (32'(addr) < 32'(DEPTH));
endmodule

module sram_port_arbiter #(
    parameter int DEPTH = 2560,
    parameter int AW    = 12,
    parameter int DW    = 32,
    parameter int FAIR  = 1,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            reset_req,

    input  logic [AW-1:0]   m0_address,
    input  logic [DW/8-1:0] m0_byteenable,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [DW-1:0]   m0_writedata,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,

    input  logic [AW-1:0]   m1_address,
    input  logic [DW/8-1:0] m1_byteenable,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [DW-1:0]   m1_writedata,
    output logic            m1_waitrequest,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_readdatavalid,

    output logic [AW-1:0]   sram_address,
    output logic [DW/8-1:0] sram_byteenable,
    output logic            sram_chipselect,
    output logic            sram_write,
    output logic [DW-1:0]   sram_writedata,
    output logic            sram_clken,
    input  logic [DW-1:0]   sram_readdata,

    output logic [ERRW-1:0] err_count,
    output logic            err_pulse
);
    localparam int NM = 2;

    // Masters packed into arrays so the datapath is indexed by grant select.
    logic [NM-1:0]                rd, wr;
    logic [NM-1:0][AW-1:0]        addr;
    logic [NM-1:0][DW/8-1:0]      be;
    logic [NM-1:0][DW-1:0]        wdata;
    logic [NM-1:0]                req, is_wr, in_rng;

    assign rd    = {m1_read, m0_read};
    assign wr    = {m1_write, m0_write};
    assign addr  = {m1_address, m0_address};
    assign be    = {m1_byteenable, m0_byteenable};
    assign wdata = {m1_writedata, m0_writedata};

    for (genvar i = 0; i < NM; i++) begin : g_req
        sram_port_arbiter_req #(.AW(AW), .DEPTH(DEPTH)) u_req (
            .rd     (rd[i]),
            .wr     (wr[i]),
            .addr   (addr[i]),
            .req    (req[i]),
            .is_wr  (is_wr[i]),
            .in_rng (in_rng[i])
        );
    end

    // State
    logic            last_grant_q, last_grant_d;
    logic            tag_vld_q, tag_vld_d;
    logic            tag_mst_q, tag_mst_d;
    logic            tag_rng_q, tag_rng_d;
    logic [ERRW-1:0] err_count_q, err_count_d;
    logic            err_pulse_q, err_pulse_d;

    logic [NM-1:0]   grant;
    logic            granted;
    logic            gsel;

    // Grant: single requester wins outright; on contention FAIR picks the
    // master not granted last, otherwise master 0 always wins.
    always_comb begin
        grant = '0;
        if (!reset_req) begin
            if (req[0] && req[1]) begin
                if (FAIR != 0 && !last_grant_q) grant = 2'b10;
                else                            grant = 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    assign granted = |grant;
    // With nothing granted gsel is 0, so the SRAM mux rests on master 0.
    assign gsel    = grant[1];

    assign m0_waitrequest = req[0] & ~grant[0];
    assign m1_waitrequest = req[1] & ~grant[1];

    assign sram_address    = addr[gsel];
    assign sram_byteenable = be[gsel];
    assign sram_writedata  = wdata[gsel];
    assign sram_chipselect = granted & in_rng[gsel];
    assign sram_write      = granted & is_wr[gsel] & in_rng[gsel];
    assign sram_clken      = ~reset_req;

    always_comb begin
        last_grant_d = granted ? gsel : last_grant_q;

        // Tag loads on every accepted read, including out-of-range reads,
        // which return zero with normal timing.
        tag_vld_d = granted & ~is_wr[gsel];
        tag_mst_d = gsel;
        tag_rng_d = in_rng[gsel];

        err_pulse_d = granted & ~in_rng[gsel];
        err_count_d = err_count_q;
        if (err_pulse_d && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;   // master 0 wins the first contention
            tag_vld_q    <= 1'b0;
            tag_mst_q    <= 1'b0;
            tag_rng_q    <= 1'b0;
            err_count_q  <= '0;
            err_pulse_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            tag_vld_q    <= tag_vld_d;
            tag_mst_q    <= tag_mst_d;
            tag_rng_q    <= tag_rng_d;
            err_count_q  <= err_count_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    // Read return: both masters see the same data bus, qualified by valid.
    assign m0_readdatavalid = tag_vld_q & ~tag_mst_q;
    assign m1_readdatavalid = tag_vld_q &  tag_mst_q;
    assign m0_readdata      = tag_rng_q ? sram_readdata : '0;
    assign m1_readdata      = tag_rng_q ? sram_readdata : '0;

    assign err_count = err_count_q;
    assign err_pulse = err_pulse_q;
endmodule
